// File: rtl/shape_motion_ctrl.sv
// shape_motion_ctrl
// Owns the square-shape position/size registers that feed the renderer. On every
// FRAME_DIV-th falling edge of vertical sync (start of the sync pulse, inside
// vertical blanking) it runs a three-cycle update: resize, move X, move Y.
//
// Ports:
//   iClk        pixel clock
//   iRst        asynchronous active-low reset
//   iVS         vertical sync, active-low pulse
//   iEnable     1 = run, 0 = pause (frame ticks ignored)
//   iSizeUp     grow request, level, sampled in the SIZE state
//   iSizeDown   shrink request, level, sampled in the SIZE state
//   oShapeX     box left edge
//   oShapeY     box top edge
//   oShapeSize  box side length
//   oDirX       1 = moving right
//   oDirY       1 = moving down
//   oFrameTick  one-cycle pulse, the cycle after each iVS falling edge
//   oBusy       high while an update is in progress
module shape_motion_ctrl #(
    parameter int unsigned WIDTH     = 640,
    parameter int unsigned HEIGHT    = 480,
    parameter int unsigned INIT_X    = 0,
    parameter int unsigned INIT_Y    = 0,
    parameter int unsigned INIT_SIZE = 32,
    parameter int unsigned MIN_SIZE  = 8,
    parameter int unsigned MAX_SIZE  = 128,
    parameter int unsigned STEP      = 2,
    parameter int unsigned FRAME_DIV = 1
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iVS,
    input  logic       iEnable,
    input  logic       iSizeUp,
    input  logic       iSizeDown,
    output logic [9:0] oShapeX,
    output logic [9:0] oShapeY,
    output logic [9:0] oShapeSize,
    output logic       oDirX,
    output logic       oDirY,
    output logic       oFrameTick,
    output logic       oBusy
);

    typedef enum logic [1:0] {StIdle, StSize, StMoveX, StMoveY} state_e;

    localparam logic [10:0] Width11  = 11'(WIDTH);
    localparam logic [10:0] Height11 = 11'(HEIGHT);
    localparam logic [10:0] Step11   = 11'(STEP);
    localparam logic [10:0] Min11    = 11'(MIN_SIZE);
    localparam logic [10:0] Max11    = 11'(MAX_SIZE);
    localparam logic [3:0]  Div4     = 4'(FRAME_DIV);

    state_e      state_q, state_d;
    logic        vs_q;
    logic        frame_tick_q;
    logic        tick;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  x_q, x_d, y_q, y_d, size_q, size_d;
    logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [10:0] size11;
    logic [10:0] step_res;

    // One axis step with edge bounce; returns {new_dir, new_pos}. All sums are
    // 11 bits wide so pos+STEP+size cannot wrap for legal parameters.
    function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic [9:0] sz,
                                              input logic [10:0] lim, input logic dir);
        logic [10:0] p;
        logic [10:0] s;
        p = {1'b0, pos};
        s = {1'b0, sz};
        if (dir) begin
            // Also re-clamps a box that a grow pushed past the far edge.
            if (p + Step11 + s >= lim) return {1'b0, 10'(lim - s)};
            return {1'b1, 10'(p + Step11)};
        end
        if (p <= Step11) return {1'b1, 10'd0};
        return {1'b0, 10'(p - Step11)};
    endfunction

    // Start of the active-low sync pulse.
    assign tick   = vs_q & ~iVS;
    assign size11 = {1'b0, size_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        size_d   = size_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        step_res = '0;
        unique case (state_q)
            StIdle: begin
                // The FSM leaves IDLE on the raw tick so that oFrameTick and the
                // first busy cycle coincide; ticks while busy never reach here.
                if (tick && iEnable) begin
                    if (cnt_q + 4'd1 >= Div4) begin
                        cnt_d   = '0;
                        state_d = StSize;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StSize: begin
                if (iSizeUp && !iSizeDown && (size11 + Step11 <= Max11)) begin
                    size_d = 10'(size11 + Step11);
                end else if (iSizeDown && !iSizeUp && (size11 >= Min11 + Step11)) begin
                    size_d = 10'(size11 - Step11);
                end
                state_d = StMoveX;
            end
            StMoveX: begin
                step_res = step_axis(x_q, size_q, Width11, dir_x_q);
                dir_x_d  = step_res[10];
                x_d      = step_res[9:0];
                state_d  = StMoveY;
            end
            StMoveY: begin
                step_res = step_axis(y_q, size_q, Height11, dir_y_q);
                dir_y_d  = step_res[10];
                y_d      = step_res[9:0];
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q      <= StIdle;
            vs_q         <= 1'b1;
            frame_tick_q <= 1'b0;
            cnt_q        <= '0;
            x_q          <= 10'(INIT_X);
            y_q          <= 10'(INIT_Y);
            size_q       <= 10'(INIT_SIZE);
            dir_x_q      <= 1'b1;
            dir_y_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            vs_q         <= iVS;
            frame_tick_q <= tick;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            size_q       <= size_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
        end
    end

    assign oShapeX    = x_q;
    assign oShapeY    = y_q;
    assign oShapeSize = size_q;
    assign oDirX      = dir_x_q;
    assign oDirY      = dir_y_q;
    assign oFrameTick = frame_tick_q;
    assign oBusy      = (state_q != StIdle);

endmodule

// File: tb/tb_shape_motion_ctrl.sv
// Bench for shape_motion_ctrl. Four instances share the stimulus:
//   u_a defaults, u_l narrow screen (WIDTH=11, size 8) for the left bounce and
//   minimum size, u_r INIT_X=606 for the right bounce, u_s INIT_SIZE=126 with
//   FRAME_DIV=3 for maximum size and the divider.
module tb_shape_motion_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vs = 1'b1;
    logic en = 1'b1;
    logic up = 1'b0;
    logic dn = 1'b0;

    logic [9:0] ax, ay, asz, lx, ly, lsz, rx, ry, rsz, sx, sy, ssz;
    logic adx, ady, atk, abz, ldx, ldy, ltk, lbz, rdx, rdy, rtk, rbz, sdx, sdy, stk, sbz;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shape_motion_ctrl u_a (
        .iClk(clk), .iRst(rst_n), .iVS(vs), .iEnable(en), .iSizeUp(up), .iSizeDown(dn),
        .oShapeX(ax), .oShapeY(ay), .oShapeSize(asz), .oDirX(adx), .oDirY(ady),
        .oFrameTick(atk), .oBusy(abz)
    );

    shape_motion_ctrl #(.WIDTH(11), .INIT_SIZE(8)) u_l (
        .iClk(clk), .iRst(rst_n), .iVS(vs), .iEnable(en), .iSizeUp(up), .iSizeDown(dn),
        .oShapeX(lx), .oShapeY(ly), .oShapeSize(lsz), .oDirX(ldx), .oDirY(ldy),
        .oFrameTick(ltk), .oBusy(lbz)
    );

    shape_motion_ctrl #(.INIT_X(606)) u_r (
        .iClk(clk), .iRst(rst_n), .iVS(vs), .iEnable(en), .iSizeUp(up), .iSizeDown(dn),
        .oShapeX(rx), .oShapeY(ry), .oShapeSize(rsz), .oDirX(rdx), .oDirY(rdy),
        .oFrameTick(rtk), .oBusy(rbz)
    );

    shape_motion_ctrl #(.INIT_SIZE(126), .FRAME_DIV(3)) u_s (
        .iClk(clk), .iRst(rst_n), .iVS(vs), .iEnable(en), .iSizeUp(up), .iSizeDown(dn),
        .oShapeX(sx), .oShapeY(sy), .oShapeSize(ssz), .oDirX(sdx), .oDirY(sdy),
        .oFrameTick(stk), .oBusy(sbz)
    );

    typedef struct {
        int vs, en, up, dn;
        int x, y, sz, tick, busy;
    } vec_t;

    vec_t tbl[28];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vs = 1'b1;
        en = 1'b1;
        up = 1'b0;
        dn = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One sync pulse long enough for the whole update, then release.
    task automatic frame();
        @(negedge clk);
        vs = 1'b0;
        repeat (5) @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lx_exp[5]  = '{2, 3, 1, 0, 2};
        int ldx_exp[5] = '{1, 0, 0, 1, 1};
        int rx_exp[2]  = '{608, 606};
        int ssz_exp[6] = '{126, 126, 128, 128, 128, 128};
        int sx_exp[6]  = '{0, 0, 2, 2, 2, 4};

        //            vs en up dn   x  y  sz tick busy
        tbl[0]  = '{1, 1, 0, 0, 0, 0, 32, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 0, 32, 1, 1};
        tbl[2]  = '{0, 1, 0, 0, 0, 0, 32, 0, 1};
        tbl[3]  = '{0, 1, 0, 0, 2, 0, 32, 0, 1};
        tbl[4]  = '{0, 1, 0, 0, 2, 2, 32, 0, 0};
        tbl[5]  = '{1, 1, 0, 0, 2, 2, 32, 0, 0};
        tbl[6]  = '{0, 1, 1, 1, 2, 2, 32, 1, 1};
        tbl[7]  = '{0, 1, 1, 1, 2, 2, 32, 0, 1};
        tbl[8]  = '{0, 1, 0, 0, 4, 2, 32, 0, 1};
        tbl[9]  = '{0, 1, 0, 0, 4, 4, 32, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 4, 4, 32, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 4, 4, 32, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 4, 4, 32, 0, 0};
        tbl[13] = '{1, 0, 0, 0, 4, 4, 32, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 4, 4, 32, 1, 0};
        tbl[15] = '{1, 0, 0, 0, 4, 4, 32, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 4, 4, 32, 1, 0};
        tbl[17] = '{0, 0, 0, 0, 4, 4, 32, 0, 0};
        tbl[18] = '{1, 1, 1, 0, 4, 4, 32, 0, 0};
        tbl[19] = '{0, 1, 1, 0, 4, 4, 32, 1, 1};
        tbl[20] = '{0, 1, 1, 0, 4, 4, 34, 0, 1};
        tbl[21] = '{0, 1, 0, 0, 6, 4, 34, 0, 1};
        tbl[22] = '{0, 1, 0, 0, 6, 6, 34, 0, 0};
        tbl[23] = '{1, 1, 0, 1, 6, 6, 34, 0, 0};
        tbl[24] = '{0, 1, 0, 1, 6, 6, 34, 1, 1};
        tbl[25] = '{0, 1, 0, 1, 6, 6, 32, 0, 1};
        tbl[26] = '{0, 1, 0, 0, 8, 6, 32, 0, 1};
        tbl[27] = '{0, 1, 0, 0, 8, 8, 32, 0, 0};

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        check("rst_x", int'(ax), 0);
        check("rst_y", int'(ay), 0);
        check("rst_size", int'(asz), 32);
        check("rst_dirx", int'(adx), 1);
        check("rst_diry", int'(ady), 1);
        check("rst_tick", int'(atk), 0);
        check("rst_busy", int'(abz), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_x", int'(ax), 0);
        check("idle_busy", int'(abz), 0);

        // Cycle-by-cycle vectors on the default instance.
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            vs = (tbl[i].vs != 0);
            en = (tbl[i].en != 0);
            up = (tbl[i].up != 0);
            dn = (tbl[i].dn != 0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_x", i), int'(ax), tbl[i].x);
            check($sformatf("v%0d_y", i), int'(ay), tbl[i].y);
            check($sformatf("v%0d_size", i), int'(asz), tbl[i].sz);
            check($sformatf("v%0d_tick", i), int'(atk), tbl[i].tick);
            check($sformatf("v%0d_busy", i), int'(abz), tbl[i].busy);
            check($sformatf("v%0d_dirx", i), int'(adx), 1);
        end

        // Right and left bounces.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            frame();
            check($sformatf("lbounce%0d_x", k), int'(lx), lx_exp[k]);
            check($sformatf("lbounce%0d_dirx", k), int'(ldx), ldx_exp[k]);
            if (k < 2) begin
                check($sformatf("rbounce%0d_x", k), int'(rx), rx_exp[k]);
                check($sformatf("rbounce%0d_dirx", k), int'(rdx), 0);
            end
        end

        // Shrink at the minimum holds.
        dn = 1'b1;
        frame();
        check("min_size_hold", int'(lsz), 8);
        dn = 1'b0;

        // Grow to the maximum with a divide-by-3 frame counter.
        do_reset();
        up = 1'b1;
        for (int k = 0; k < 6; k++) begin
            frame();
            check($sformatf("max%0d_size", k), int'(ssz), ssz_exp[k]);
            check($sformatf("div%0d_x", k), int'(sx), sx_exp[k]);
        end
        up = 1'b0;

        // Reset asserted while in MOVE_X.
        do_reset();
        frame();
        check("pre_x", int'(ax), 2);
        check("pre_y", int'(ay), 2);
        @(negedge clk);
        vs = 1'b0;
        repeat (2) @(negedge clk);
        check("midupd_busy", int'(abz), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_x", int'(ax), 0);
        check("midrst_y", int'(ay), 0);
        check("midrst_size", int'(asz), 32);
        check("midrst_dirx", int'(adx), 1);
        check("midrst_busy", int'(abz), 0);
        vs = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_x", int'(ax), 0);
        check("postrst_y", int'(ay), 0);
        check("postrst_busy", int'(abz), 0);
        frame();
        check("resume_x", int'(ax), 2);
        check("resume_y", int'(ay), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
